// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states,
// bus size codes and small op-classification helpers.
package mem_lsu_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] LD_B     = 4'd1;
    localparam logic [3:0] LD_H     = 4'd2;
    localparam logic [3:0] LD_W     = 4'd3;
    localparam logic [3:0] LD_BU    = 4'd4;
    localparam logic [3:0] LD_HU    = 4'd5;
    localparam logic [3:0] ST_B     = 4'd6;
    localparam logic [3:0] ST_H     = 4'd7;
    localparam logic [3:0] ST_W     = 4'd8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DONE      = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            LD_B, LD_H, LD_W, LD_BU, LD_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            ST_B, ST_H, ST_W: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            LD_B, LD_BU, ST_B: return SIZE_B;
            LD_H, LD_HU, ST_H: return SIZE_H;
            default:           return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the
// returned bus word and sign- or zero-extends it to register width.
module mem_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the low address bits; halfwords only look at bit 1
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension per load flavour; anything that is not a narrow load passes the word through
    always_comb begin
        data_o = rdata_i;
        case (mem_op_i)
            LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {24'd0, byte_sel};
            LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through, runs loads/stores over an
// SRAM-like addr_ok/data_ok bus, stalls upstream while an access is in flight
// and produces the bundle consumed by the mem_wb register.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_reg2,
    input  logic [31:0]       ex_inst_pc,
    input  logic [31:0]       ex_instr,
    input  logic              ex_inst_valid,
    output logic              stallreq_mem,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       mem_inst_pc,
    output logic [31:0]       mem_instr,
    output logic              mem_inst_valid
);

    lsu_state_e        state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              mem_access;
    logic              op_is_load;
    logic              op_is_store;
    logic [1:0]        req_size;
    logic [1:0]        addr_lo;
    logic [1:0]        aligned_lo;
    logic [3:0]        store_strb;
    logic [DATA_W-1:0] store_wdata;
    logic [DATA_W-1:0] load_data;

    assign op_is_load  = is_load(ex_mem_op);
    assign op_is_store = is_store(ex_mem_op);
    assign mem_access  = ex_inst_valid && (op_is_load || op_is_store);
    assign req_size    = op_size(ex_mem_op);
    assign addr_lo     = ex_mem_addr[1:0];

    mem_load_align u_load_align (
        .rdata_i   (rdata_q),
        .mem_op_i  (ex_mem_op),
        .addr_lo_i (addr_lo),
        .data_o    (load_data)
    );

    // State, cancel flag and captured read data; everything else is combinational
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            rdata_q  <= rdata_d;
        end
    end

    // Store lane steering and size alignment: misaligned low bits are silently forced down
    always_comb begin
        store_strb  = 4'b1111;
        store_wdata = ex_reg2;
        aligned_lo  = 2'b00;
        case (req_size)
            SIZE_B: begin
                store_strb  = 4'b0001 << addr_lo;
                store_wdata = {4{ex_reg2[7:0]}};
                aligned_lo  = addr_lo;
            end
            SIZE_H: begin
                store_strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{ex_reg2[15:0]}};
                aligned_lo  = {addr_lo[1], 1'b0};
            end
            default: begin
                store_strb  = 4'b1111;
                store_wdata = ex_reg2;
                aligned_lo  = 2'b00;
            end
        endcase
    end

    // Next-state and output decode; defaults describe a bubble with an idle bus
    always_comb begin
        state_d        = state_q;
        cancel_d       = cancel_q;
        rdata_d        = rdata_q;
        stallreq_mem   = 1'b0;
        data_req       = 1'b0;
        data_wr        = 1'b0;
        data_size      = 2'b00;
        data_wstrb     = 4'b0000;
        data_addr      = '0;
        data_wdata     = '0;
        mem_wd         = 5'd0;
        mem_wreg       = 1'b0;
        mem_wdata      = '0;
        mem_inst_pc    = 32'd0;
        mem_instr      = 32'd0;
        mem_inst_valid = 1'b1;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_access) begin
                        stallreq_mem = 1'b1;
                        data_req     = 1'b1;
                        data_wr      = op_is_store;
                        data_size    = req_size;
                        data_wstrb   = op_is_store ? store_strb : 4'b0000;
                        data_addr    = {ex_mem_addr[ADDR_W-1:2], aligned_lo};
                        data_wdata   = op_is_store ? store_wdata : '0;
                        if (data_addr_ok) begin
                            state_d  = WAIT_DATA;
                            cancel_d = flush;
                        end
                    end else if (!flush) begin
                        mem_wd         = ex_wd;
                        mem_wreg       = ex_wreg;
                        mem_wdata      = ex_wdata;
                        mem_inst_pc    = ex_inst_pc;
                        mem_instr      = ex_instr;
                        mem_inst_valid = ~ex_inst_valid;
                    end
                end
                WAIT_DATA: begin
                    stallreq_mem = 1'b1;
                    if (flush) begin
                        cancel_d = 1'b1;
                    end
                    if (data_data_ok) begin
                        rdata_d = data_rdata;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                    if (!cancel_q && !flush) begin
                        mem_wd         = ex_wd;
                        mem_wreg       = op_is_store ? 1'b0 : ex_wreg;
                        mem_wdata      = op_is_load ? load_data : ex_wdata;
                        mem_inst_pc    = ex_inst_pc;
                        mem_instr      = ex_instr;
                        mem_inst_valid = 1'b0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios with literal expectations, then a
// randomized pipeline/bus environment checked every cycle against an
// access-level model of the stage.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [31:0] ex_inst_pc;
    logic [31:0] ex_instr;
    logic        ex_inst_valid;
    logic        stallreq_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_inst_pc;
    logic [31:0] mem_instr;
    logic        mem_inst_valid;

    int total = 0;
    int bad   = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_inst_pc(ex_inst_pc), .ex_instr(ex_instr), .ex_inst_valid(ex_inst_valid),
        .stallreq_mem(stallreq_mem),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_inst_pc(mem_inst_pc), .mem_instr(mem_instr), .mem_inst_valid(mem_inst_valid)
    );

    always #5 clk = ~clk;

    // Hard stop in case something upstream of the bench wedges the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not finish, got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- access-level reference model ----------------
    function automatic bit isLoad(input logic [3:0] op);
        return (op == LD_B) || (op == LD_H) || (op == LD_W) || (op == LD_BU) || (op == LD_HU);
    endfunction

    function automatic bit isStore(input logic [3:0] op);
        return (op == ST_B) || (op == ST_H) || (op == ST_W);
    endfunction

    function automatic int sizeBytes(input logic [3:0] op);
        if ((op == LD_B) || (op == LD_BU) || (op == ST_B)) return 1;
        if ((op == LD_H) || (op == LD_HU) || (op == ST_H)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] extendLoad(input logic [3:0] op, input logic [31:0] rd, input logic [31:0] addr);
        logic [31:0] b, h;
        int lane;
        lane = int'(addr % 32'd4);
        b = (rd >> (8 * lane)) & 32'h0000_00FF;
        h = (rd >> (16 * (lane / 2))) & 32'h0000_FFFF;
        if (op == LD_B)  return (b >= 32'd128)   ? b - 32'd256   : b;
        if (op == LD_BU) return b;
        if (op == LD_H)  return (h >= 32'd32768) ? h - 32'd65536 : h;
        if (op == LD_HU) return h;
        return rd;
    endfunction

    // Model state in bus terms: an accepted access awaiting data, a result due this cycle, killed flag
    bit          mBusy = 1'b0;
    bit          mHave = 1'b0;
    bit          mKill = 1'b0;
    logic [31:0] mData = 32'd0;

    logic        eStall, eReq, eWr, eWreg, eBub;
    logic [1:0]  eSize;
    logic [3:0]  eStrb;
    logic [4:0]  eWd;
    logic [31:0] eAddr, eWdata, eMw, ePc, eInstr;

    task automatic computeExpected();
        int n;
        int lane;
        eStall = 0; eReq = 0; eWr = 0; eSize = 0; eStrb = 0; eAddr = 0; eWdata = 0;
        eWd = 0; eWreg = 0; eMw = 0; ePc = 0; eInstr = 0; eBub = 1;
        n    = sizeBytes(ex_mem_op);
        lane = int'(ex_mem_addr % 32'd4);
        if (rst) begin
            eBub = 1;
        end else if (mHave) begin
            if (!(mKill || flush)) begin
                eWd    = ex_wd;
                eWreg  = isStore(ex_mem_op) ? 1'b0 : ex_wreg;
                eMw    = isLoad(ex_mem_op) ? extendLoad(ex_mem_op, mData, ex_mem_addr) : ex_wdata;
                ePc    = ex_inst_pc;
                eInstr = ex_instr;
                eBub   = 0;
            end
        end else if (mBusy) begin
            eStall = 1;
        end else if (ex_inst_valid && (isLoad(ex_mem_op) || isStore(ex_mem_op))) begin
            eStall = 1;
            eReq   = 1;
            eWr    = isStore(ex_mem_op);
            eSize  = 2'(n / 2);
            eAddr  = ex_mem_addr - (ex_mem_addr % 32'(n));
            if (isStore(ex_mem_op)) begin
                if (n == 1) begin
                    eStrb  = 4'(1 << lane);
                    eWdata = (ex_reg2 & 32'h0000_00FF) * 32'h0101_0101;
                end else if (n == 2) begin
                    eStrb  = (lane >= 2) ? 4'd12 : 4'd3;
                    eWdata = (ex_reg2 & 32'h0000_FFFF) * 32'h0001_0001;
                end else begin
                    eStrb  = 4'd15;
                    eWdata = ex_reg2;
                end
            end
        end else if (!flush) begin
            eWd    = ex_wd;
            eWreg  = ex_wreg;
            eMw    = ex_wdata;
            ePc    = ex_inst_pc;
            eInstr = ex_instr;
            eBub   = !ex_inst_valid;
        end
    endtask

    // Advance the model on every clock edge from the inputs held during the cycle
    always @(posedge clk) begin
        if (rst) begin
            mBusy <= 1'b0; mHave <= 1'b0; mKill <= 1'b0;
        end else if (mHave) begin
            mHave <= 1'b0; mKill <= 1'b0;
        end else if (mBusy) begin
            if (flush) mKill <= 1'b1;
            if (data_data_ok) begin
                mBusy <= 1'b0; mHave <= 1'b1; mData <= data_rdata;
            end
        end else if (ex_inst_valid && (isLoad(ex_mem_op) || isStore(ex_mem_op)) && data_addr_ok) begin
            mBusy <= 1'b1; mKill <= flush;
        end
    end

    // Compare every DUT output against the model mid-cycle, away from the clock edge
    always @(negedge clk) begin
        computeExpected();
        checkOutput("stallreq_mem",   32'(stallreq_mem),   32'(eStall));
        checkOutput("data_req",       32'(data_req),       32'(eReq));
        checkOutput("data_wr",        32'(data_wr),        32'(eWr));
        checkOutput("data_size",      32'(data_size),      32'(eSize));
        checkOutput("data_wstrb",     32'(data_wstrb),     32'(eStrb));
        checkOutput("data_addr",      data_addr,           eAddr);
        checkOutput("data_wdata",     data_wdata,          eWdata);
        checkOutput("mem_wd",         32'(mem_wd),         32'(eWd));
        checkOutput("mem_wreg",       32'(mem_wreg),       32'(eWreg));
        checkOutput("mem_wdata",      mem_wdata,           eMw);
        checkOutput("mem_inst_pc",    mem_inst_pc,         ePc);
        checkOutput("mem_instr",      mem_instr,           eInstr);
        checkOutput("mem_inst_valid", 32'(mem_inst_valid), 32'(eBub));
    end

    // ---------------- stimulus ----------------
    task automatic clearInputs();
        flush = 0; ex_wd = 0; ex_wreg = 0; ex_wdata = 0; ex_mem_op = MEM_NONE;
        ex_mem_addr = 0; ex_reg2 = 0; ex_inst_pc = 0; ex_instr = 0; ex_inst_valid = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                 input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                 input logic [31:0] pc, input logic [31:0] instr, input logic valid);
        ex_mem_op = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wd = wd; ex_wreg = wreg;
        ex_wdata = wdata; ex_inst_pc = pc; ex_instr = instr; ex_inst_valid = valid;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic newInstr(input bit bubble);
        int pick;
        logic [3:0] op;
        pick = $urandom_range(0, 13);
        op = (pick < 6) ? MEM_NONE : 4'(pick - 5);
        if (bubble)
            applyStimulus(MEM_NONE, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'b0);
        else
            applyStimulus(op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                          ($urandom_range(0, 9) != 0));
    endtask

    initial begin
        int  stallCount;
        bit  outstanding;
        int  addrWait;
        int  dataWait;
        bit  stallS, flushS, rstS, reqS;

        clearInputs();
        rst = 1;
        @(negedge clk);
        checkOutput("rst_bubble", 32'(mem_inst_valid), 32'd1);
        checkOutput("rst_stall",  32'(stallreq_mem),   32'd0);
        checkOutput("rst_req",    32'(data_req),       32'd0);
        nextCycle();
        nextCycle();
        rst = 0;
        @(negedge clk);
        checkOutput("idle_bubble", 32'(mem_inst_valid), 32'd1);
        checkOutput("idle_wdata",  mem_wdata,           32'd0);

        // ALU pass-through
        nextCycle();
        applyStimulus(MEM_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h100, 32'h0000_0013, 1'b1);
        @(negedge clk);
        checkOutput("add_wd",    32'(mem_wd),         32'd5);
        checkOutput("add_wdata", mem_wdata,           32'h1234);
        checkOutput("add_valid", 32'(mem_inst_valid), 32'd0);
        checkOutput("add_stall", 32'(stallreq_mem),   32'd0);

        // LD_B with immediate acceptance and one-cycle response
        stallCount = 0;
        nextCycle();
        applyStimulus(LD_B, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h5555, 32'h104, 32'h0, 1'b1);
        data_addr_ok = 1;
        @(negedge clk);
        checkOutput("ldb_req",  32'(data_req), 32'd1);
        checkOutput("ldb_addr", data_addr,     32'h1003);
        stallCount += int'(stallreq_mem);
        nextCycle();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80FF_FFFF;
        @(negedge clk);
        stallCount += int'(stallreq_mem);
        nextCycle();
        data_data_ok = 0;
        @(negedge clk);
        stallCount += int'(stallreq_mem);
        checkOutput("ldb_wdata",  mem_wdata,           32'hFFFF_FF80);
        checkOutput("ldb_valid",  32'(mem_inst_valid), 32'd0);
        checkOutput("ldb_stalls", 32'(stallCount),     32'd2);

        // ST_H to the upper halfword
        nextCycle();
        applyStimulus(ST_H, 32'h2002, 32'h0000_ABCD, 5'd3, 1'b1, 32'h0, 32'h108, 32'h0, 1'b1);
        data_addr_ok = 1;
        @(negedge clk);
        checkOutput("sth_strb",  32'(data_wstrb), 32'hC);
        checkOutput("sth_wdata", data_wdata,      32'hABCD_ABCD);
        checkOutput("sth_addr",  data_addr,       32'h2002);
        nextCycle();
        data_addr_ok = 0; data_data_ok = 1;
        nextCycle();
        data_data_ok = 0;
        @(negedge clk);
        checkOutput("sth_wreg",  32'(mem_wreg),       32'd0);
        checkOutput("sth_valid", 32'(mem_inst_valid), 32'd0);

        // Address phase held off for three cycles; request must stay put
        nextCycle();
        applyStimulus(LD_W, 32'h3006, 32'h0, 5'd4, 1'b1, 32'h0, 32'h10C, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            @(negedge clk);
            checkOutput("hold_req",  32'(data_req), 32'd1);
            checkOutput("hold_addr", data_addr,     32'h3004);
            if (i < 3) nextCycle();
        end
        nextCycle();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_BABE;
        nextCycle();
        data_data_ok = 0;
        @(negedge clk);
        checkOutput("hold_wdata", mem_wdata, 32'hCAFE_BABE);

        // Flush while waiting for load data
        nextCycle();
        applyStimulus(LD_W, 32'h4000, 32'h0, 5'd6, 1'b1, 32'h0, 32'h110, 32'h0, 1'b1);
        data_addr_ok = 1;
        nextCycle();
        data_addr_ok = 0; flush = 1;
        nextCycle();
        flush = 0; data_data_ok = 1; data_rdata = 32'h1111_2222;
        nextCycle();
        data_data_ok = 0;
        @(negedge clk);
        checkOutput("flush_valid", 32'(mem_inst_valid), 32'd1);
        checkOutput("flush_wreg",  32'(mem_wreg),       32'd0);
        nextCycle();
        applyStimulus(MEM_NONE, 32'h0, 32'h0, 5'd9, 1'b1, 32'h77, 32'h114, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("after_flush_valid", 32'(mem_inst_valid), 32'd0);
        checkOutput("after_flush_wd",    32'(mem_wd),         32'd9);

        // Reset while an access is outstanding
        nextCycle();
        applyStimulus(LD_W, 32'h5000, 32'h0, 5'd2, 1'b1, 32'h0, 32'h118, 32'h0, 1'b1);
        data_addr_ok = 1;
        nextCycle();
        data_addr_ok = 0; rst = 1;
        nextCycle();
        rst = 0;
        clearInputs();
        @(negedge clk);
        checkOutput("rstmid_valid", 32'(mem_inst_valid), 32'd1);
        checkOutput("rstmid_stall", 32'(stallreq_mem),   32'd0);
        checkOutput("rstmid_req",   32'(data_req),       32'd0);
        checkOutput("rstmid_wdata", mem_wdata,           32'd0);

        // Randomized pipeline and bus: upstream holds on stall, replaces on flush
        outstanding = 0; addrWait = 0; dataWait = 0;
        stallS = 0; flushS = 0; rstS = 0; reqS = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nextCycle();
            rst = ($urandom_range(0, 399) == 0);
            if (rst) outstanding = 0;
            if (!stallS || flushS || rstS) begin
                newInstr(flushS);
                addrWait = $urandom_range(0, 3);
            end
            flush = ($urandom_range(0, 19) == 0);
            #1;
            data_addr_ok = data_req && (addrWait == 0);
            data_rdata   = $urandom;
            data_data_ok = outstanding ? (dataWait == 0) : ($urandom_range(0, 7) == 0);
            @(negedge clk);
            stallS = stallreq_mem; reqS = data_req; flushS = flush; rstS = rst;
            if (!rst) begin
                if (outstanding) begin
                    if (data_data_ok) outstanding = 0;
                    else dataWait--;
                end else if (reqS) begin
                    if (data_addr_ok) begin
                        outstanding = 1;
                        dataWait = $urandom_range(0, 2);
                    end else begin
                        addrWait--;
                    end
                end
            end
        end

        nextCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage between the ex_mem register and the mem_wb register.
- Passes ALU results straight through and executes loads/stores over an SRAM-like request/response data bus.
- While an access is in flight, it stalls upstream and emits bubbles.
- Produces the exact bundle consumed by mem_wb: destination, write enable, data, PC, instruction word, bubble flag.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, register and data-bus width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill the current instruction (exception/branch redirect).
- ex_wd  in  5  destination register address.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  32  ALU result (pass-through for non-memory ops).
- ex_mem_op  in  4  memory op code (package constants).
- ex_mem_addr  in  32  effective address.
- ex_reg2  in  32  store data.
- ex_inst_pc  in  32  instruction PC.
- ex_instr  in  32  instruction word.
- ex_inst_valid  in  1  1 = real instruction.
- stallreq_mem  out  1  hold ex_mem and all earlier stages.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  out  4  byte strobes.
- data_addr  out  32  bus address.
- data_wdata  out  32  store data, lane-replicated.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data / write ack returned.
- data_rdata  in  32  read data.
- mem_wd  out  5  to mem_wb.
- mem_wreg  out  1  to mem_wb.
- mem_wdata  out  32  to mem_wb.
- mem_inst_pc  out  32  to mem_wb.
- mem_instr  out  32  to mem_wb.
- mem_inst_valid  out  1  bubble flag: 0 = valid instruction, 1 = bubble. The downstream register inverts it to form the commit-valid signal.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state = IDLE, cancel = 0, rdata_q = 0.
  - All bus outputs 0.
  - mem_wd = 0, mem_wreg = 0, mem_wdata = 0, mem_inst_pc = 0, mem_instr = 0, mem_inst_valid = 1 (bubble), stallreq_mem = 0.
- Outputs are combinational from state and inputs; only state, cancel and rdata_q are registered.
- Upstream holds the ex_* inputs stable whenever stallreq_mem = 1.
- Non-memory op (MEM_NONE) in IDLE:
  - Zero-latency pass-through of ex_*.
  - mem_inst_valid = ~ex_inst_valid; stallreq_mem = 0.
- IDLE with a memory op and ex_inst_valid = 1:
  - data_req = 1, stallreq_mem = 1, outputs are a bubble.
  - data_addr = {ex_mem_addr[31:2], size-aligned low bits}. Misaligned low bits are forced to alignment; no exception is raised here.
  - On data_addr_ok: go to WAIT_DATA. Otherwise stay in IDLE with the request held stable.
- WAIT_DATA:
  - data_req = 0, stallreq_mem = 1, bubble.
  - On data_data_ok: rdata_q <= data_rdata; go to DONE.
- DONE:
  - stallreq_mem = 0.
  - Present ex_* with mem_wdata = load_align(rdata_q, ex_mem_op, addr[1:0]).
  - Stores present mem_wreg = 0, mem_inst_valid = 0.
  - If cancel = 1: bubble with mem_wreg = 0.
  - Next cycle: IDLE, cancel <= 0.
- Load extension:
  - LD_B / LD_H sign-extend the selected byte/halfword; LD_BU / LD_HU zero-extend.
  - Lane chosen by addr[1:0] (halfword uses addr[1]).
- Store strobes:
  - ST_B: wstrb = 1 << addr[1:0], wdata = {4{reg2[7:0]}}.
  - ST_H: wstrb = addr[1] ? 1100 : 0011, wdata = {2{reg2[15:0]}}.
  - ST_W: wstrb = 1111, wdata = reg2.
  - Loads: wstrb = 0.
- Latency with a 1-cycle-response bus: a load occupies 3 cycles (IDLE, WAIT_DATA, DONE); minimum stall 2 cycles.
- Flush:
  - IDLE, before addr_ok: drop the request, bubble, stay IDLE, no bus transaction.
  - flush coincident with addr_ok in IDLE: the transaction is accepted, so go to WAIT_DATA with cancel <= 1.
  - WAIT_DATA: cancel <= 1; the outstanding response must still be absorbed.
  - DONE: output bubble.
- data_data_ok in IDLE (spurious): ignored.
- Reset mid-transaction: return to IDLE immediately; bus-side recovery is the interconnect's responsibility.

Decomposition:
- Shared package:
  - MEM_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W op codes (4-bit).
  - lsu state encoding (IDLE = 0, WAIT_DATA = 1, DONE = 2).
  - size codes.
- One sub-module: mem_load_align, combinational lane select and sign/zero extension.

Test Plan:
- ADD pass-through: ex_wd = 5, ex_wdata = 0x1234 in IDLE -> same cycle mem_wd = 5, mem_wdata = 0x1234, mem_inst_valid = 0, stallreq_mem = 0.
- LD_B at addr 0x1003, addr_ok same cycle, data_ok next cycle with rdata 0x80FFFFFF -> DONE cycle mem_wdata = 0xFFFFFF80; stallreq_mem high exactly 2 cycles.
- ST_H at 0x2002, reg2 = 0xABCD -> data_wstrb = 1100, data_wdata = 0xABCDABCD, data_addr = 0x2002; DONE gives mem_wreg = 0.
- addr_ok withheld 3 cycles -> data_req and data_addr stable all 4 cycles; result unchanged.
- flush during WAIT_DATA for LD_W -> data_ok absorbed; DONE outputs mem_inst_valid = 1, mem_wreg = 0; the next instruction is processed normally.
- rst asserted in WAIT_DATA -> next cycle state IDLE, all outputs at reset values, mem_inst_valid = 1.
